// File: rtl/dispense_pkg.sv
// Shared definitions for the dispense sequencer and the continuous-servo PWM stage.
// The servo codes must stay in step with the PWM stage's decoder.
package dispense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH     = 3'd1,
    ST_SETTLE_P = 3'd2,
    ST_REVERT   = 3'd3,
    ST_SETTLE_R = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  localparam logic [1:0] SERVO_STOP   = 2'b00;
  localparam logic [1:0] SERVO_PUSH   = 2'b01;
  localparam logic [1:0] SERVO_REVERT = 2'b10;

  // Only the two motion states move the servo; 2'b11 is never produced.
  function automatic logic [1:0] servo_code(input state_t s);
    case (s)
      ST_PUSH:   return SERVO_PUSH;
      ST_REVERT: return SERVO_REVERT;
      default:   return SERVO_STOP;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Restartable millisecond tick: one-cycle pulse every DIV cycles, counted
// from the cycle after i_restart was last high.
module ms_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Decoded from the register so that restart never feeds back into tick.
  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/dispense_sequencer.sv
// Dispense sequencer: for each requested item drives PUSH, settle, REVERT,
// settle on the continuous servo, with a safe abort path back through REVERT.
//
// Request handshake: req_ready is high only in IDLE; a request (req_count) is
// taken on a rising clk edge where req_valid && req_ready, and req_valid /
// req_count are ignored at every other time.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int PUSH_MS   = 800,
  parameter int REVERT_MS = 800,
  parameter int SETTLE_MS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_count,
  output logic       req_ready,
  input  logic       abort,
  output logic [1:0] servo_control,
  output logic       busy,
  output logic [3:0] items_left,
  output logic       done,
  output logic       aborted,
  output state_t     o_dbg_state
);

  localparam int DIV    = CLK_FREQ / 1000;
  localparam int MS_MAX = max3(PUSH_MS, REVERT_MS, SETTLE_MS);
  localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX + 1) : 1;

  localparam logic [MS_W-1:0] PUSH_LAST   = MS_W'(PUSH_MS - 1);
  localparam logic [MS_W-1:0] REVERT_LAST = MS_W'(REVERT_MS - 1);
  localparam logic [MS_W-1:0] SETTLE_LAST = MS_W'(SETTLE_MS - 1);

  state_t          r_state;
  logic [MS_W-1:0] r_ms_cnt;
  logic            r_abort_seen;
  logic [3:0]      r_items;
  logic [1:0]      r_servo;
  logic            r_busy;
  logic            r_req_ready;
  logic            r_done;
  logic            r_aborted;

  state_t          w_next;
  logic            w_tick;
  logic            w_restart;
  logic            w_accept;
  logic            w_phase_done;
  logic            w_abort_now;
  logic [MS_W-1:0] w_ms_last;

  // Restart on every state change keeps each phase exactly N full milliseconds.
  ms_tick_gen #(
    .DIV (DIV)
  ) u_ms_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_ms_last = SETTLE_LAST;
    case (r_state)
      ST_PUSH:   w_ms_last = PUSH_LAST;
      ST_REVERT: w_ms_last = REVERT_LAST;
      default:   w_ms_last = SETTLE_LAST;
    endcase
  end

  assign w_phase_done = w_tick && (r_ms_cnt == w_ms_last);
  assign w_accept     = req_valid && r_req_ready;
  assign w_abort_now  = abort && (r_state inside {ST_PUSH, ST_SETTLE_P, ST_REVERT, ST_SETTLE_R});

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = (req_count != 4'd0) ? ST_PUSH : ST_FINISH;
      end
      ST_PUSH: begin
        if (abort)             w_next = ST_REVERT;
        else if (w_phase_done) w_next = ST_SETTLE_P;
      end
      ST_SETTLE_P: begin
        if (abort || w_phase_done) w_next = ST_REVERT;
      end
      ST_REVERT: begin
        if (w_phase_done) w_next = ST_SETTLE_R;
      end
      ST_SETTLE_R: begin
        if (w_phase_done) begin
          w_next = (r_abort_seen || abort || (r_items == 4'd1)) ? ST_FINISH : ST_PUSH;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // IDLE holds the tick generator cleared so the first PUSH ms is full length.
  assign w_restart = (w_next != r_state) || (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ms_cnt     <= '0;
      r_abort_seen <= 1'b0;
      r_items      <= 4'd0;
      r_servo      <= SERVO_STOP;
      r_busy       <= 1'b0;
      r_req_ready  <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_restart)   r_ms_cnt <= '0;
      else if (w_tick) r_ms_cnt <= r_ms_cnt + 1'b1;

      if (r_state == ST_IDLE) r_abort_seen <= 1'b0;
      else if (w_abort_now)   r_abort_seen <= 1'b1;

      if ((w_next == ST_FINISH) || (w_next == ST_IDLE)) begin
        r_items <= 4'd0;
      end else if ((r_state == ST_IDLE) && w_accept) begin
        r_items <= req_count;
      end else if ((r_state == ST_SETTLE_R) && (w_next == ST_PUSH)) begin
        r_items <= r_items - 4'd1;
      end

      // Outputs are registered from the next state so they align with r_state.
      r_servo     <= servo_code(w_next);
      r_busy      <= (w_next != ST_IDLE);
      r_req_ready <= (w_next == ST_IDLE);
      r_done      <= (w_next == ST_FINISH);
      r_aborted   <= (w_next == ST_FINISH) && (r_abort_seen || w_abort_now);
    end
  end

  assign req_ready     = r_req_ready;
  assign servo_control = r_servo;
  assign busy          = r_busy;
  assign items_left    = r_items;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/dispense_sequencer.md
DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter PUSH_MS, default 800, duration of the PUSH phase in ms.
REQ-003 Parameter REVERT_MS, default 800, duration of the REVERT phase in ms.
REQ-004 Parameter SETTLE_MS, default 300, STOP dwell after each motion phase, in ms.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  dispense request present.
REQ-008 req_count  input  4  number of items to dispense (0-15).
REQ-009 req_ready  output  1  high only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-010 abort  input  1  level; stop the current sequence safely.
REQ-011 servo_control  output  2  00 STOP, 01 PUSH, 10 REVERT; drives the continuous-servo PWM stage.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 items_left  output  4  items still to dispense, including the current item.
REQ-014 done  output  1  one-cycle pulse when a sequence ends.
REQ-015 aborted  output  1  qualifies done; high on the done cycle if the sequence ended by abort.

Function
REQ-016 States: IDLE, PUSH, SETTLE_P, REVERT, SETTLE_R, FINISH.
REQ-017 All outputs are registered; servo_control SHALL never be 11.
REQ-018 servo_control mapping: PUSH->01, REVERT->10, all other states->00.
REQ-019 On acceptance with req_count>0: next cycle PUSH, items_left=req_count.
REQ-020 On acceptance with req_count=0: next cycle FINISH; no servo motion.
REQ-021 Each timed phase lasts exactly its parameter in ms × (CLK_FREQ/1000) cycles, counted from the first cycle in the state.
REQ-022 Phase timer restarts on every state entry; no phase is shortened by residual prescaler count.
REQ-023 Sequence: PUSH -> SETTLE_P -> REVERT -> SETTLE_R.
REQ-024 At the end of SETTLE_R: items_left decrements. If the result is nonzero, go to PUSH; otherwise go to FINISH.
REQ-025 FINISH lasts one cycle and asserts done, then returns to IDLE.
REQ-026 Abort in PUSH or SETTLE_P: go to REVERT next cycle with the full REVERT_MS, then SETTLE_R, then FINISH with aborted=1.
REQ-027 Abort in REVERT or SETTLE_R: complete the current phases, then FINISH with aborted=1; no further PUSH.
REQ-028 Abort is sticky for the rest of the sequence once sampled.
REQ-029 Abort in IDLE is ignored. A request and abort in the same IDLE cycle: the request is accepted and the abort is not latched.
REQ-030 The req_valid/req_count values are ignored while busy; req_count is captured only at acceptance.
REQ-031 items_left is 0 in IDLE and holds 0 on the FINISH cycle.

Reset
REQ-032 Asynchronous reset SHALL force state IDLE, servo_control=00, busy=0, done=0, aborted=0, items_left=0, and clear all timers, including mid-phase.
REQ-033 After reset release, req_ready=1 on the first clock edge.

Structure
REQ-034 Package dispense_pkg SHALL hold the state encoding and the servo codes SERVO_STOP=00, SERVO_PUSH=01, SERVO_REVERT=10, shared with the PWM servo stage.
REQ-035 Sub-module ms_tick_gen SHALL provide a restartable 1 ms tick: a one-cycle pulse every CLK_FREQ/1000 cycles, cleared by a restart input.
REQ-036 The phase ms counter SHALL be wide enough for max(PUSH_MS, REVERT_MS, SETTLE_MS).
REQ-037 servo_control connects directly to the PWM stage's servo_control input.

Verification
All scenarios use CLK_FREQ=10_000 (10 cycles/ms), PUSH_MS=3, REVERT_MS=2, SETTLE_MS=1.
REQ-038 Single item: req_count=1 -> servo_control 01 for 30 cycles, 00 for 10, 10 for 20, 00 for 10; then done=1 with aborted=0; 72 cycles acceptance-to-done.
REQ-039 Three items: req_count=3 -> three identical PUSH/REVERT cycles; items_left steps 3,2,1,0; exactly one done pulse.
REQ-040 Zero count: req_count=0 -> done pulse 2 cycles after acceptance; servo_control stays 00.
REQ-041 Abort in PUSH: req_count=5, abort pulse at cycle 15 of PUSH -> REVERT for 20 cycles, STOP for 10, then done with aborted=1 and items_left=0.
REQ-042 Busy-ignored: req_valid held through a sequence -> no second acceptance until IDLE; req_ready=0 throughout busy.
REQ-043 Reset mid-REVERT: assert rst_n=0 -> servo_control=00 and busy=0 immediately (asynchronous); a new request is accepted normally afterwards.
